// File: rtl/alu_fifo_pkg.sv
// Shared types and widths for the ALU command master: command packing,
// result width, outstanding counter width and the issue FSM state encoding.
// Optional statistics counters are enabled with ALU_CMD_STATS_EN.
package alu_fifo_pkg;

    // Field widths of a command and of a returned result
    localparam int unsigned OP_W   = 2;
    localparam int unsigned OPND_W = 4;
    localparam int unsigned CMD_W  = 10;
    localparam int unsigned RES_W  = 9;

    // Outstanding counter width; MAX_OUT must fit in it
    localparam int unsigned OUT_W  = 4;

    // Bit positions of the command fields inside cmd_data
    localparam int unsigned CMD_OP_LSB = 8;
    localparam int unsigned CMD_A_LSB  = 4;
    localparam int unsigned CMD_B_LSB  = 0;

`ifdef ALU_CMD_STATS_EN
    // Width of the wrapping statistics counters
    localparam int unsigned STAT_W = 16;
`endif

    // ALU operation encoding carried in the op field
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } alu_op_e;

    // Command payload as it appears on cmd_data (op in the MSBs)
    typedef struct packed {
        alu_op_e             op;
        logic [OPND_W-1:0]   a;
        logic [OPND_W-1:0]   b;
    } alu_cmd_t;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } cmd_state_e;

    // Place the request fields at their command bit positions
    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [OP_W-1:0]   op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        logic [CMD_W-1:0] cmd;
        cmd = '0;
        cmd[CMD_OP_LSB +: OP_W]  = op;
        cmd[CMD_A_LSB  +: OPND_W] = a;
        cmd[CMD_B_LSB  +: OPND_W] = b;
        return cmd;
    endfunction

endpackage

// File: rtl/alu_cmd_queue.sv
// Synchronous command FIFO with full/empty/last flags and a head taken
// straight from the storage registers. A push to a full queue is accepted
// when a pop happens in the same cycle; i_clear empties it and wins over
// any push in that cycle.
module alu_cmd_queue
    import alu_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_last
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic [AW:0]      w_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Occupancy flags from the extra wrap bit of the pointers
    always_comb begin
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
        w_count   = r_wr_ptr - r_rd_ptr;
        w_pop_ok  = i_pop && !w_empty;
        w_push_ok = i_push && (!w_full || w_pop_ok);
    end

    // Pointer update; clear discards everything including a same-cycle push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Entry storage; payload only, occupancy lives in the pointers
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_last  = (w_count == (AW+1)'(1));

endmodule

// File: rtl/alu_cmd_master.sv
// Host-to-ALU command master: queues host requests, issues them to the ALU
// FIFO under an outstanding-command credit limit, forwards results with one
// cycle of latency and supports a flush that discards queued commands and
// waits for in-flight results. Define ALU_CMD_STATS_EN to add the
// stat_issued/stat_done counters.
module alu_cmd_master
    import alu_fifo_pkg::*;
#(
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [OPND_W-1:0] req_a,
    input  logic [OPND_W-1:0] req_b,
    output logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              res_valid,
    input  logic [RES_W-1:0]  res_data,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic [OUT_W-1:0]  outstanding,
    output logic              err_unexp,
    input  logic              flush,
    output logic              busy
`ifdef ALU_CMD_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0] stat_done
`endif
);

    cmd_state_e       r_state;
    cmd_state_e       w_state_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_ret;
    logic             w_unexp;
    logic             w_q_full;
    logic             w_q_empty;
    logic             w_q_last;
    logic             w_q_nonempty_nxt;
    logic [CMD_W-1:0] w_cmd_in;
    logic [CMD_W-1:0] w_q_head;
    logic [OUT_W-1:0] w_out_nxt;
    logic             w_cmd_valid;
    logic             w_req_ready;

    logic [OUT_W-1:0] r_outstanding;
    logic             r_out_valid;
    logic [RES_W-1:0] r_out_data;
    logic             r_err_unexp;

    // Handshakes, credit bookkeeping and queue occupancy after this edge
    always_comb begin
        w_cmd_in         = pack_cmd(req_op, req_a, req_b);
        w_push           = req_valid && w_req_ready;
        w_pop            = w_cmd_valid && cmd_ready;
        w_ret            = res_valid && (r_outstanding != '0);
        w_unexp          = res_valid && (r_outstanding == '0);
        w_out_nxt        = r_outstanding + OUT_W'(w_pop) - OUT_W'(w_ret);
        w_q_nonempty_nxt = w_push || (!w_q_empty && !(w_q_last && w_pop));
    end

    alu_cmd_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (CMD_W)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_head  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_last  (w_q_last)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: the credit limit outranks queue occupancy, flush outranks all
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_DRAIN;
        end else begin
            unique case (r_state)
                ST_DRAIN: begin
                    if (r_outstanding == '0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    if (w_out_nxt == OUT_W'(MAX_OUT)) begin
                        w_state_nxt = ST_STALL;
                    end else if (w_q_nonempty_nxt) begin
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register and queue flags
    always_comb begin
        w_cmd_valid = 1'b0;
        w_req_ready = 1'b0;
        unique case (r_state)
            ST_IDLE:  w_req_ready = !w_q_full;
            ST_SEND: begin
                w_req_ready = !w_q_full;
                w_cmd_valid = 1'b1;
            end
            ST_STALL: w_req_ready = !w_q_full;
            ST_DRAIN: w_req_ready = 1'b0;
            default:  w_req_ready = 1'b0;
        endcase
    end

    // Outstanding credit count; unexpected results never underflow it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
        end
    end

    // Result forwarding stage and sticky unexpected-result flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err_unexp <= 1'b0;
        end else begin
            r_out_valid <= res_valid;
            if (res_valid) begin
                r_out_data <= res_data;
            end
            if (w_unexp) begin
                r_err_unexp <= 1'b1;
            end
        end
    end

`ifdef ALU_CMD_STATS_EN
    logic [STAT_W-1:0] r_stat_issued;
    logic [STAT_W-1:0] r_stat_done;

    // Wrapping counters of command transfers and result beats
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_issued <= '0;
            r_stat_done   <= '0;
        end else begin
            if (w_pop) begin
                r_stat_issued <= r_stat_issued + STAT_W'(1);
            end
            if (res_valid) begin
                r_stat_done <= r_stat_done + STAT_W'(1);
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_done   = r_stat_done;
`endif

    // Head data is only meaningful while presented, so hold zero otherwise
    assign cmd_data    = w_cmd_valid ? w_q_head : '0;
    assign cmd_valid   = w_cmd_valid;
    assign req_ready   = w_req_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign outstanding = r_outstanding;
    assign err_unexp   = r_err_unexp;
    assign busy        = !w_q_empty || (r_outstanding != '0);

endmodule

// File: tb/tb_alu_cmd_master.sv
// Self-checking bench for alu_cmd_master: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_alu_cmd_master;

    localparam int QD = 4;
    localparam int MO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [9:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       res_valid;
    logic [8:0] res_data;
    logic       out_valid;
    logic [8:0] out_data;
    logic [3:0] outstanding;
    logic       err_unexp;
    logic       flush;
    logic       busy;
`ifdef ALU_CMD_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_done;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0] m_q[$];
    int         m_out;
    bit         m_drain;
    bit         m_err;
    bit         m_ov;
    logic [8:0] m_od;
    int         m_issued;
    int         m_done;

    always #5 clk = ~clk;

    alu_cmd_master #(
        .QDEPTH  (QD),
        .MAX_OUT (MO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .outstanding (outstanding),
        .err_unexp   (err_unexp),
        .flush       (flush),
        .busy        (busy)
`ifdef ALU_CMD_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_done   (stat_done)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_req_ready();
        return (m_q.size() < QD) && !m_drain;
    endfunction

    function automatic bit exp_cmd_valid();
        return !m_drain && (m_q.size() > 0) && (m_out < MO);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_out    = 0;
        m_drain  = 0;
        m_err    = 0;
        m_ov     = 0;
        m_od     = '0;
        m_issued = 0;
        m_done   = 0;
    endtask

    task automatic check_all();
        chk("req_ready", 16'(req_ready), 16'(exp_req_ready()));
        chk("cmd_valid", 16'(cmd_valid), 16'(exp_cmd_valid()));
        if (exp_cmd_valid()) chk("cmd_data", 16'(cmd_data), 16'(m_q[0]));
        chk("out_valid", 16'(out_valid), 16'(m_ov));
        if (m_ov) chk("out_data", 16'(out_data), 16'(m_od));
        chk("outstanding", 16'(outstanding), 16'(m_out));
        chk("err_unexp", 16'(err_unexp), 16'(m_err));
        chk("busy", 16'(busy), 16'((m_q.size() > 0) || (m_out != 0)));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 16'(req_ready), 16'd1);
        chk({tag, "_cmd_valid"}, 16'(cmd_valid), 16'd0);
        chk({tag, "_cmd_data"}, 16'(cmd_data), 16'd0);
        chk({tag, "_out_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "_out_data"}, 16'(out_data), 16'd0);
        chk({tag, "_outstanding"}, 16'(outstanding), 16'd0);
        chk({tag, "_err_unexp"}, 16'(err_unexp), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    // One clock: apply the model's rules to the inputs seen at the edge, then compare
    task automatic step(output bit acc);
        bit pv;
        bit pr;
        bit pop;
        bit ret;
        int old_out;
        pv = exp_cmd_valid();
        pr = exp_req_ready();
        @(posedge clk);
        acc = req_valid && pr;
        pop = pv && cmd_ready;
        ret = res_valid && (m_out > 0);
        if (res_valid && (m_out == 0)) m_err = 1;
        if (res_valid) m_done++;
        m_ov = res_valid;
        if (res_valid) m_od = res_data;
        old_out = m_out;
        if (pop) begin
            void'(m_q.pop_front());
            m_issued++;
        end
        m_out = m_out + int'(pop) - int'(ret);
        if (acc) m_q.push_back({req_op, req_a, req_b});
        if (flush) begin
            m_q.delete();
            m_drain = 1;
        end else if (m_drain && (old_out == 0)) begin
            m_drain = 0;
        end
        #1;
        check_all();
    endtask

    task automatic tick();
        bit d;
        step(d);
    endtask

    task automatic idle_inputs();
        req_valid = 0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        cmd_ready = 0;
        res_valid = 0;
        res_data  = '0;
        flush     = 0;
    endtask

    // Present one request until accepted, with a bounded wait
    task automatic send_req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bit acc;
        acc       = 0;
        req_valid = 1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 40 && !acc; i++) step(acc);
        if (!acc) chk("req_accept_timeout", 16'd0, 16'd1);
        req_valid = 0;
    endtask

    // Return results until nothing is queued or in flight, with a bounded wait
    task automatic drain_all();
        for (int i = 0; i < 100 && (m_out > 0 || m_q.size() > 0); i++) begin
            res_valid = (m_out > 0);
            res_data  = 9'($urandom);
            tick();
        end
        res_valid = 0;
        chk("drain_outstanding", 16'(outstanding), 16'd0);
    endtask

    initial begin
        logic [9:0] seq [3];
        seq[0] = 10'h151;
        seq[1] = 10'h232;
        seq[2] = 10'h140;

        m_reset();
        idle_inputs();
        reset = 0;
        #3;
        chk_reset("por");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por_hold");
        reset = 1;

        // Single command issue with cmd_ready high
        cmd_ready = 1;
        send_req(2'd1, 4'd6, 4'd3);
        chk("single_cmd_valid", 16'(cmd_valid), 16'd1);
        chk("single_cmd_data", 16'(cmd_data), 16'h163);
        tick();
        chk("single_cmd_valid_drop", 16'(cmd_valid), 16'd0);
        chk("single_outstanding", 16'(outstanding), 16'd1);
        res_valid = 1;
        res_data  = 9'h009;
        tick();
        res_valid = 0;
        chk("single_out_data", 16'(out_data), 16'h009);
        chk("single_outstanding_ret", 16'(outstanding), 16'd0);

        // Backpressure holds the head stable, then in-order issue
        cmd_ready = 0;
        send_req(2'd1, 4'd5, 4'd1);
        send_req(2'd2, 4'd3, 4'd2);
        send_req(2'd1, 4'd4, 4'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 16'(cmd_data), 16'h151);
        end
        cmd_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_order_data", 16'(cmd_data), 16'(seq[k]));
            tick();
        end
        chk("bp_outstanding", 16'(outstanding), 16'd3);

        // Transfer and return in the same cycle
        cmd_ready = 0;
        send_req(2'd3, 4'd15, 4'd15);
        cmd_ready = 1;
        res_valid = 1;
        res_data  = 9'h1FF;
        tick();
        cmd_ready = 0;
        res_valid = 0;
        chk("same_cycle_outstanding", 16'(outstanding), 16'd3);
        drain_all();

        // Credit limit: stall at MAX_OUT, resume on a return
        cmd_ready = 1;
        for (int i = 0; i < 10; i++) send_req(2'($urandom), 4'(i), 4'(i + 1));
        tick();
        tick();
        chk("stall_outstanding", 16'(outstanding), 16'd8);
        chk("stall_cmd_valid", 16'(cmd_valid), 16'd0);
        res_valid = 1;
        res_data  = 9'h0A5;
        tick();
        res_valid = 0;
        chk("stall_out_valid", 16'(out_valid), 16'd1);
        chk("stall_out_data", 16'(out_data), 16'h0A5);
        chk("stall_outstanding_ret", 16'(outstanding), 16'd7);
        chk("stall_resume_valid", 16'(cmd_valid), 16'd1);
        tick();
        chk("stall_again_outstanding", 16'(outstanding), 16'd8);
        drain_all();

        // Flush with 3 queued and 2 outstanding
        cmd_ready = 0;
        for (int i = 0; i < 4; i++) send_req(2'd0, 4'(i), 4'd9);
        cmd_ready = 1;
        tick();
        tick();
        cmd_ready = 0;
        send_req(2'd2, 4'd7, 4'd7);
        chk("flush_pre_outstanding", 16'(outstanding), 16'd2);
        flush = 1;
        tick();
        flush = 0;
        cmd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req_ready", 16'(req_ready), 16'd0);
            chk("drain_busy", 16'(busy), 16'd1);
            tick();
        end
        res_valid = 1;
        tick();
        chk("drain_busy_one", 16'(busy), 16'd1);
        tick();
        res_valid = 0;
        chk("drain_busy_done", 16'(busy), 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_no_issue", 16'(cmd_valid), 16'd0);
        end
        chk("drain_idle_ready", 16'(req_ready), 16'd1);
        chk("drain_idle_outstanding", 16'(outstanding), 16'd0);

        // Unexpected result and reset in the middle of SEND
        cmd_ready = 0;
        res_valid = 1;
        res_data  = 9'h133;
        tick();
        res_valid = 0;
        chk("unexp_err", 16'(err_unexp), 16'd1);
        chk("unexp_outstanding", 16'(outstanding), 16'd0);
        chk("unexp_out_data", 16'(out_data), 16'h133);
        send_req(2'd1, 4'd2, 4'd2);
        chk("midsend_valid", 16'(cmd_valid), 16'd1);
        #2;
        reset = 0;
        #1;
        chk_reset("midsend");
        m_reset();
        #1;
        reset = 1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 700; i++) begin
            req_valid = 1'($urandom % 2);
            req_op    = 2'($urandom);
            req_a     = 4'($urandom);
            req_b     = 4'($urandom);
            cmd_ready = ($urandom % 4) != 0;
            res_valid = (m_out > 0) ? (($urandom % 3) == 0) : (($urandom % 50) == 0);
            res_data  = 9'($urandom);
            flush     = ($urandom % 60) == 0;
            tick();
        end
        idle_inputs();
        drain_all();

`ifdef ALU_CMD_STATS_EN
        chk("stat_issued", stat_issued, 16'(m_issued));
        chk("stat_done", stat_done, 16'(m_done));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
